// File: rtl/raymarch_pixel_writer.sv
// raymarch_pixel_writer
//   Sits downstream of a fixed-latency, non-stallable raymarcher. Each accepted issue (x,y) is
//   tracked through a PIPE_LATENCY-deep delay line so the returning RGB can be re-tagged with its
//   pixel coordinates. The colour is packed to RGB332 and queued, then written to the framebuffer
//   over a valid/ready port. Issue is credit-gated so the queue can never overflow.
//
// Optional feature: define RAYMARCH_WRITER_DITHER_EN to enable a 2x2 ordered dither before
// truncation. The default build uses plain truncation.
//
// Ports
//   i_clk          system clock, all logic on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_issue_valid  sequencer presented i_issue_x/i_issue_y to the raymarcher this cycle
//   i_issue_x/y    issued pixel column/row
//   o_issue_ready  a credit is free; an issue counts only when valid && ready
//   i_red/green/blue  raymarcher colour, valid PIPE_LATENCY cycles after issue
//   o_fb_valid     framebuffer write request (queue non-empty)
//   i_fb_ready     framebuffer accepts the write
//   o_fb_addr      y*SCREEN_WIDTH + x
//   o_fb_data      RGB332 {r[7:5],g[7:5],b[7:6]}
//   o_frame_done   one-cycle pulse after the last pixel of the frame is written
//   o_err_sticky   issue without credit, queue overflow or out-of-range coordinate
module raymarch_pixel_writer #(
    parameter int unsigned PIPE_LATENCY  = 20,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned CORDW         = 10,
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned ADDR_W        = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue_valid,
    input  logic [CORDW-1:0]  i_issue_x,
    input  logic [CORDW-1:0]  i_issue_y,
    output logic              o_issue_ready,
    input  logic [7:0]        i_red,
    input  logic [7:0]        i_green,
    input  logic [7:0]        i_blue,
    output logic              o_fb_valid,
    input  logic              i_fb_ready,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [7:0]        o_fb_data,
    output logic              o_frame_done,
    output logic              o_err_sticky
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = 1 + ADDR_W + 8;

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_credits_used;
    logic             w_accept;
    logic             r_tap_v;

    // In-flight covers both the delay line and the tap register, so the sum
    // with queue occupancy bounds the queue: a push can never meet a full queue.
    assign w_credits_used = (CNT_W + 1)'(r_inflight) + (CNT_W + 1)'(r_count);
    assign o_issue_ready  = w_credits_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign w_accept       = i_issue_valid && o_issue_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(r_tap_v);
        end
    end

    // ------------------------------------------------------------------
    // Delay line mirroring the raymarcher latency
    // ------------------------------------------------------------------
    logic [PIPE_LATENCY-1:0] r_dl_v;
    logic [CORDW-1:0]        r_dl_x [PIPE_LATENCY];
    logic [CORDW-1:0]        r_dl_y [PIPE_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dl_v <= '0;
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                r_dl_v[i] <= r_dl_v[i-1];
            end
            r_dl_v[0] <= w_accept;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
            r_dl_x[i] <= r_dl_x[i-1];
            r_dl_y[i] <= r_dl_y[i-1];
        end
        r_dl_x[0] <= i_issue_x;
        r_dl_y[0] <= i_issue_y;
    end

    // ------------------------------------------------------------------
    // Tap: colour arrives while the last stage is valid
    // ------------------------------------------------------------------
    logic             w_tap_v;
    logic [CORDW-1:0] w_tap_x;
    logic [CORDW-1:0] w_tap_y;
    logic [ADDR_W-1:0] w_addr;
    logic             w_last;
    logic             w_oor;
    logic [7:0]       w_r;
    logic [7:0]       w_g;
    logic [7:0]       w_b;

    assign w_tap_v = r_dl_v[PIPE_LATENCY-1];
    assign w_tap_x = r_dl_x[PIPE_LATENCY-1];
    assign w_tap_y = r_dl_y[PIPE_LATENCY-1];

    assign w_addr = ADDR_W'(w_tap_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(w_tap_x);
    assign w_last = (w_tap_x == CORDW'(SCREEN_WIDTH - 1)) && (w_tap_y == CORDW'(SCREEN_HEIGHT - 1));
    assign w_oor  = (32'(w_tap_x) >= SCREEN_WIDTH) || (32'(w_tap_y) >= SCREEN_HEIGHT);

`ifdef RAYMARCH_WRITER_DITHER_EN
    logic [7:0] w_dith_off;
    logic [8:0] w_r_sum;
    logic [8:0] w_g_sum;
    logic [8:0] w_b_sum;

    always_comb begin
        w_dith_off = 8'd0;
        unique case ({w_tap_y[0], w_tap_x[0]})
            2'b00: w_dith_off = 8'd0;
            2'b01: w_dith_off = 8'd16;
            2'b10: w_dith_off = 8'd24;
            2'b11: w_dith_off = 8'd8;
            default: w_dith_off = 8'd0;
        endcase
    end

    assign w_r_sum = {1'b0, i_red} + {1'b0, w_dith_off};
    assign w_g_sum = {1'b0, i_green} + {1'b0, w_dith_off};
    assign w_b_sum = {1'b0, i_blue} + {w_dith_off, 1'b0};
    // Saturate so a bright channel never wraps to dark.
    assign w_r = w_r_sum[8] ? 8'hFF : w_r_sum[7:0];
    assign w_g = w_g_sum[8] ? 8'hFF : w_g_sum[7:0];
    assign w_b = w_b_sum[8] ? 8'hFF : w_b_sum[7:0];
`else
    assign w_r = i_red;
    assign w_g = i_green;
    assign w_b = i_blue;
`endif

    // Registered multiply-add and pack; this stage stands in for the output
    // register a direct tap-to-queue path would otherwise need.
    logic [ADDR_W-1:0] r_tap_addr;
    logic [7:0]        r_tap_data;
    logic              r_tap_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap_v <= 1'b0;
        end else begin
            r_tap_v <= w_tap_v;
        end
    end

    always_ff @(posedge i_clk) begin
        r_tap_addr <= w_addr;
        r_tap_data <= {w_r[7:5], w_g[7:5], w_b[7:6]};
        r_tap_last <= w_last;
    end

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop  = o_fb_valid && i_fb_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push = r_tap_v && (!w_full || w_pop);
    assign w_drop = r_tap_v && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_tap_last, r_tap_addr, r_tap_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign o_fb_valid = (r_count != '0);
    assign o_fb_addr  = w_head[ADDR_W+7:8];
    assign o_fb_data  = w_head[7:0];

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic r_frame_done;
    logic r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_head[ENTRY_W-1];
            if ((i_issue_valid && !o_issue_ready) || w_drop || (w_tap_v && w_oor)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_err_sticky = r_err;

endmodule

// File: tb/tb_raymarch_pixel_writer.sv
module tb_raymarch_pixel_writer;

    localparam int LAT = 20;
    localparam int W   = 640;
    localparam int H   = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [9:0]  issue_x = '0;
    logic [9:0]  issue_y = '0;
    logic        issue_ready;
    logic [7:0]  red, green, blue;
    logic        fb_valid;
    logic        fb_ready = 1'b1;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        frame_done;
    logic        err_sticky;

    always #5 clk = ~clk;

    raymarch_pixel_writer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_x     (issue_x),
        .i_issue_y     (issue_y),
        .o_issue_ready (issue_ready),
        .i_red         (red),
        .i_green       (green),
        .i_blue        (blue),
        .o_fb_valid    (fb_valid),
        .i_fb_ready    (fb_ready),
        .o_fb_addr     (fb_addr),
        .o_fb_data     (fb_data),
        .o_frame_done  (frame_done),
        .o_err_sticky  (err_sticky)
    );

    // Raymarcher stand-in: colour presented exactly LAT cycles after issue.
    logic [23:0] rm_in = '0;
    logic [23:0] rm_dl [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rm_dl[i] <= rm_dl[i-1];
        rm_dl[0] <= rm_in;
    end
    assign {red, green, blue} = rm_dl[LAT-1];

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pack(input int x, input int y,
                                        input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        int ro, go, bo, off;
        ro = r; go = g; bo = b;
`ifdef RAYMARCH_WRITER_DITHER_EN
        case ({y[0], x[0]})
            2'b00: off = 0;
            2'b01: off = 16;
            2'b10: off = 24;
            default: off = 8;
        endcase
        ro = (ro + off > 255) ? 255 : ro + off;
        go = (go + off > 255) ? 255 : go + off;
        bo = (bo + 2 * off > 255) ? 255 : bo + 2 * off;
`else
        off = x + y;
        off = 0;
        ro = ro + off;
`endif
        return {ro[7:5], go[7:5], bo[7:6]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one issue cycle; called and returns at posedge+1.
    task automatic issue_px(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input int ea, input logic [7:0] ed,
                            input bit force_v, output bit acc);
        exp_t e;
        issue_valid = force_v || issue_ready;
        issue_x     = 10'(x);
        issue_y     = 10'(y);
        rm_in       = {r, g, b};
        acc         = issue_valid && issue_ready;
        if (acc && rst_n) begin
            e.addr = 19'(ea);
            e.data = ed;
            e.last = (x == W - 1) && (y == H - 1);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Issues n pixels of row y from column x0, honouring credits.
    task automatic stream(input int x0, input int y, input int n);
        int  k;
        bit  acc;
        logic [7:0] r, g, b;
        k = 0;
        for (int c = 0; c < 2000 && k < n; c++) begin
            r = 8'(x0 + k);
            g = 8'hA5;
            b = 8'((k * 37) & 8'hFF);
            issue_px(x0 + k, y, r, g, b, y * W + x0 + k, pack(x0 + k, y, r, g, b), 1'b0, acc);
            if (acc) k++;
        end
        chk("stream_issued", 64'(k), 64'(n));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q.size() != 0 || fb_valid) && c < 500) begin
            cyc(1);
            c++;
        end
        chk("drain_timeout", 64'(c < 500), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold while stalled.
    initial begin : monitor
        exp_t        e;
        bit          stall_prev;
        bit          fd_pend;
        logic [18:0] pa;
        logic [7:0]  pd;
        stall_prev = 0;
        fd_pend    = 0;
        pa         = '0;
        pd         = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
                fd_pend    = 0;
            end else begin
                if (fd_pend || frame_done) chk("frame_done", 64'(frame_done), 64'(fd_pend));
                fd_pend = 0;
                if (stall_prev) chk("stall_hold", {fb_valid, fb_addr, fb_data}, {1'b1, pa, pd});
                if (fb_valid && fb_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                                 fb_addr, fb_data);
                    end else begin
                        e = q.pop_front();
                        chk("fb_addr", 64'(fb_addr), 64'(e.addr));
                        chk("fb_data", 64'(fb_data), 64'(e.data));
                        fd_pend = e.last;
                    end
                end
                stall_prev = fb_valid && !fb_ready;
                pa = fb_addr;
                pd = fb_data;
            end
        end
    end

    initial begin : stim
        bit acc;
        int n;
        int lat;

        // Reset: issue_ready reads 1, issues during reset are discarded.
        cyc(2);
        chk("rst_fb_valid", 64'(fb_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        issue_px(3, 3, 8'h11, 8'h22, 8'h33, 0, 8'h00, 1'b1, acc);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);
        chk("rst_addr_data", {fb_addr, fb_data}, 64'd0);

        // Single pixel (5,2) FF/00/80 -> addr 1285, data E2, visible 21 cycles after acceptance.
        issue_px(5, 2, 8'hFF, 8'h00, 8'h80, 1285, 8'hE2, 1'b0, acc);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            cyc(1);
            if (fb_valid) lat = i;
        end
        chk("latency", 64'(lat), 64'd21);
        drain();

        // End of frame run: single frame_done on 307199.
        stream(600, H - 1, 40);
        drain();

        // Backpressure: exactly FIFO_DEPTH credits.
        fb_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            issue_px(i, 10, 8'(i * 13), 8'h40, 8'hC0, 10 * W + i, pack(i, 10, 8'(i * 13), 8'h40,
                     8'hC0), 1'b0, acc);
            if (acc) n++;
        end
        chk("credit_accepted", 64'(n), 64'd16);
        chk("credit_ready_low", 64'(issue_ready), 64'd0);
        cyc(30);
        chk("credit_ready_held", 64'(issue_ready), 64'd0);
        chk("err_before_force", 64'(err_sticky), 64'd0);
        issue_px(100, 10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b1, acc);
        chk("err_forced_issue", 64'(err_sticky), 64'd1);
        fb_ready = 1'b1;
        drain();

        // fb_ready toggling mid-stream.
        fork
            stream(0, 20, 24);
            repeat (150) begin
                @(posedge clk);
                #1;
                fb_ready = ~fb_ready;
            end
        join
        fb_ready = 1'b1;
        drain();

        // Colour vectors at (1,0).
        issue_px(1, 0, 8'hF0, 8'hF0, 8'hF0, 1, 8'hFF, 1'b0, acc);
`ifdef RAYMARCH_WRITER_DITHER_EN
        issue_px(1, 0, 8'h10, 8'h10, 8'h10, 1, 8'h24, 1'b0, acc);
`else
        issue_px(1, 0, 8'h10, 8'h10, 8'h10, 1, 8'h00, 1'b0, acc);
`endif
        issue_px(2, 0, 8'h00, 8'hFF, 8'h00, 2, 8'h1C, 1'b0, acc);
        drain();

        // Mid-operation reset: 4 queued, 10 in flight.
        fb_ready = 1'b0;
        stream(0, 30, 4);
        cyc(25);
        stream(4, 30, 10);
        cyc(3);
        chk("pre_reset_valid", 64'(fb_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valid", 64'(fb_valid), 64'd0);
        q.delete();
        cyc(2);
        rst_n    = 1'b1;
        fb_ready = 1'b1;
        cyc(40);
        chk("post_reset_idle", 64'(fb_valid), 64'd0);
        chk("post_reset_err", 64'(err_sticky), 64'd0);
        chk("post_reset_ready", 64'(issue_ready), 64'd1);

        // Out-of-range column is written at its computed address and flagged.
        issue_px(700, 1, 8'h00, 8'hFF, 8'h00, 1340, 8'h1C, 1'b0, acc);
        drain();
        chk("err_out_of_range", 64'(err_sticky), 64'd1);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
